store_buffer: RTL
=================

Name: store_buffer

Overview:
- Posted-write FIFO between the core's store path and the word-addressed data memory.
- Core stores are accepted in one cycle and queued. The buffer drains one entry per cycle into DM via its str/A/D/pc inputs.
- Loads check all queued stores so the core never reads stale data from DM.
- Sits directly upstream of DM. The DM read port still serves loads when ld_hit is 0.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- PTR_W, 2, log2(DEPTH); sizes the pointers. The count is PTR_W+1 bits.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset; asynchronous, active-low. Asserted (0) clears all state immediately.
- st_valid  input  1  core presents a store this cycle.
- st_addr  input  [13:2]  store word address.
- st_data  input  32  store data.
- st_pc  input  32  pc of the store instruction, carried for the DM trace.
- st_ready  output  1  buffer can accept a store this cycle.
- ld_addr  input  [13:2]  load word address, compared every cycle.
- ld_hit  output  1  at least one queued entry matches ld_addr.
- ld_data  output  32  data of the youngest matching entry; 0 when ld_hit is 0.
- mem_hold  input  1  1 suppresses the drain this cycle.
- mem_str  output  1  drives DM str.
- mem_A  output  [13:2]  drives DM A.
- mem_D  output  32  drives DM D.
- mem_pc  output  32  drives DM pc.
- empty  output  1  no entries queued.

Behaviour:
- State: DEPTH entries of {addr, data, pc}, head and tail pointers, count.
  - Pointers wrap modulo DEPTH.
  - No separate FSM; occupancy is the state (EMPTY: count=0, PARTIAL, FULL: count=DEPTH).
- Reset (rst=0, asynchronous): head=tail=count=0. All pending stores are discarded, including any reset mid-drain.
  - Outputs while in reset: st_ready=1, empty=1, mem_str=0, ld_hit=0, ld_data=0.
  - Entry contents need not be cleared.
- st_ready = (count != DEPTH). It is combinational and does not depend on a same-cycle drain.
- Enqueue when st_valid && st_ready: write {st_addr, st_data, st_pc} at tail; tail+1 at posedge.
  - st_valid while st_ready=0 is ignored. The core is required to stall.
- Drain: mem_str = (count != 0) && !mem_hold.
  - mem_A, mem_D and mem_pc always show the head entry (combinational).
  - When mem_str=1, DM writes at the same posedge and head advances by 1.
- Latency: a store accepted in cycle N reaches DM no earlier than the posedge ending cycle N+1. It is never written combinationally through.
- Simultaneous enqueue and drain: count is unchanged; head and tail both advance.
  - Count arithmetic: count + enq - deq, never wraps.
- Load forwarding (combinational):
  - Compare ld_addr against every valid entry, i.e. slots head .. head+count-1 modulo DEPTH.
  - Youngest match, closest to tail, wins.
  - A store being enqueued in the same cycle is not forwarded.
  - The head entry being drained this cycle is still forwarded this cycle.
- Ordering: DM sees stores in exact acceptance order. Repeated addresses are all written unless the optional feature is enabled.
- empty = (count == 0).

Optional Feature:
- Macro: STORE_BUFFER_COALESCE_EN.
- Defined: if an accepted store's st_addr equals the youngest valid entry's address, that entry's data and pc are overwritten in place. No slot is allocated and tail and count are unchanged.
  - Exception: if that entry is also the head and mem_str=1 this cycle, allocate normally.
  - In coalesce case, st_ready is 1 even when full.
- Undefined: every accepted store allocates a new entry, as described in Behaviour.

Test Plan:
- Reset: rst=0 mid-run with count=3 → immediately empty=1, mem_str=0, st_ready=1; after rst=1, no stale writes reach DM.
- Single store: st_addr=0x004, st_data=0xDEADBEEF, st_pc=0x3000 → next cycle mem_str=1, mem_A=0x004, mem_D=0xDEADBEEF, mem_pc=0x3000; following cycle empty=1.
- Fill and backpressure: mem_hold=1, four stores to 0x001–0x004 → st_ready=0 after the 4th; a 5th st_valid is dropped. Release mem_hold → DM receives 0x001, 0x002, 0x003, 0x004 in four consecutive cycles.
- Forwarding: mem_hold=1, store 0x010←0x11111111, then 0x010←0x22222222, ld_addr=0x010 → ld_hit=1, ld_data=0x22222222; ld_addr=0x011 → ld_hit=0, ld_data=0.
- Simultaneous enqueue and drain at count=2, with pointers wrapping past DEPTH-1 → count stays 2; DM write order matches acceptance order across the wrap.
- Coalescing (STORE_BUFFER_COALESCE_EN defined, mem_hold=1): two stores to 0x020 → count=1, entry data equals the second value. With the macro undefined, count=2.

Source files
------------

// File: rtl/store_buffer.sv
// Posted-write store buffer between the core store path and word-addressed DM.
// Optional define STORE_BUFFER_COALESCE_EN merges a store into the youngest entry on address match.
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_valid,
    input  logic [13:2]  st_addr,
    input  logic [31:0]  st_data,
    input  logic [31:0]  st_pc,
    output logic         st_ready,
    input  logic [13:2]  ld_addr,
    output logic         ld_hit,
    output logic [31:0]  ld_data,
    input  logic         mem_hold,
    output logic         mem_str,
    output logic [13:2]  mem_A,
    output logic [31:0]  mem_D,
    output logic [31:0]  mem_pc,
    output logic         empty
);

    logic [13:2]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      pc_q   [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;

    logic             full;
    logic             enq;
    logic             coalesce;
    logic [PTR_W-1:0] slot;

`ifdef STORE_BUFFER_COALESCE_EN
    logic [PTR_W-1:0] youngest;
    assign youngest = tail - PTR_W'(1);
`endif

    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);

    assign mem_A  = addr_q[head];
    assign mem_D  = data_q[head];
    assign mem_pc = pc_q[head];

    always_comb begin
        mem_str  = !empty && !mem_hold;
        coalesce = 1'b0;
`ifdef STORE_BUFFER_COALESCE_EN
        // A lone head entry leaving this cycle cannot absorb the store; it must allocate.
        coalesce = st_valid && !empty && (addr_q[youngest] == st_addr)
                   && !((count == (PTR_W+1)'(1)) && mem_str);
`endif
        st_ready = !full || coalesce;
        enq      = st_valid && st_ready && !coalesce;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + PTR_W'(1);
            end
            if (mem_str) begin
                head <= head + PTR_W'(1);
            end
            if (enq && !mem_str) begin
                count <= count + (PTR_W+1)'(1);
            end else if (!enq && mem_str) begin
                count <= count - (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail] <= st_addr;
            data_q[tail] <= st_data;
            pc_q[tail]   <= st_pc;
        end
`ifdef STORE_BUFFER_COALESCE_EN
        else if (coalesce) begin
            data_q[youngest] <= st_data;
            pc_q[youngest]   <= st_pc;
        end
`endif
    end

    // Scan oldest to youngest so the last match written is the youngest.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        slot    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot = head + PTR_W'(i);
            if (((PTR_W+1)'(i) < count) && (addr_q[slot] == ld_addr)) begin
                ld_hit  = 1'b1;
                ld_data = data_q[slot];
            end
        end
    end

endmodule
